// File: rtl/egress_drain_arbiter.sv
// Reader side of the four destination FIFOs: weighted round-robin pops, absorbs the 1-cycle
// FIFO read latency and presents one word per cycle to the sink through a 2-entry buffer.
module egress_drain_arbiter #(
  parameter int unsigned W0 = 4,
  parameter int unsigned W1 = 3,
  parameter int unsigned W2 = 2,
  parameter int unsigned W3 = 1
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic [3:0]  state,
  input  logic        empty_0,
  input  logic        empty_1,
  input  logic        empty_2,
  input  logic        empty_3,
  input  logic [11:0] data_0,
  input  logic [11:0] data_1,
  input  logic [11:0] data_2,
  input  logic [11:0] data_3,
  input  logic        sink_ready,
  output logic        pop_0,
  output logic        pop_1,
  output logic        pop_2,
  output logic        pop_3,
  output logic        valid_out,
  output logic [11:0] data_out,
  output logic [1:0]  src_out,
  output logic        idle
);

  localparam logic [3:0] StReset  = 4'b0001;
  localparam logic [3:0] StIdle   = 4'b0100;
  localparam logic [3:0] StActive = 4'b1000;

  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  burst_q, burst_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  inflight_src_q, inflight_src_d;
  logic [13:0] head_q, head_d;
  logic [13:0] tail_q, tail_d;
  logic [1:0]  occ_q, occ_d;

  logic        sync_clr;
  logic        arb_en;
  logic [3:0]  empty_vec;
  logic        accept;
  logic [2:0]  load;
  logic        credit;
  logic        found;
  logic [1:0]  chosen;
  logic [1:0]  cand;
  logic [3:0]  w_sel;
  logic [3:0]  base_cnt;
  logic [3:0]  next_cnt;
  logic        do_pop;
  logic [3:0]  pop_vec;
  logic [11:0] cap_data;
  logic [13:0] cap_word;

  assign sync_clr  = (state == StReset);
  assign arb_en    = (state == StIdle) || (state == StActive);
  assign empty_vec = {empty_3, empty_2, empty_1, empty_0};

  assign valid_out = (occ_q != 2'd0);
  assign accept    = valid_out & sink_ready;

  // Slots already committed: buffered words plus the word still coming back from a FIFO.
  assign load   = {1'b0, occ_q} + {2'b00, inflight_q};
  assign credit = (load < 3'd2) || ((load == 3'd2) && accept);

  always_comb begin
    found  = 1'b0;
    chosen = ptr_q;
    cand   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && !empty_vec[cand]) begin
        found  = 1'b1;
        chosen = cand;
      end
    end
  end

  always_comb begin
    w_sel = 4'(W0);
    unique case (chosen)
      2'd0: w_sel = 4'(W0);
      2'd1: w_sel = 4'(W1);
      2'd2: w_sel = 4'(W2);
      2'd3: w_sel = 4'(W3);
      default: w_sel = 4'(W0);
    endcase
  end

  assign do_pop  = reset_L & arb_en & credit & found;
  assign pop_vec = do_pop ? (4'b0001 << chosen) : 4'b0000;
  assign pop_0   = pop_vec[0];
  assign pop_1   = pop_vec[1];
  assign pop_2   = pop_vec[2];
  assign pop_3   = pop_vec[3];

  // Switching to a new FIFO starts its burst count from zero.
  assign base_cnt = (chosen == ptr_q) ? burst_q : 4'd0;
  assign next_cnt = base_cnt + 4'd1;

  always_comb begin
    ptr_d   = ptr_q;
    burst_d = burst_q;
    if (do_pop) begin
      if (next_cnt >= w_sel) begin
        ptr_d   = chosen + 2'd1;
        burst_d = 4'd0;
      end else begin
        ptr_d   = chosen;
        burst_d = next_cnt;
      end
    end
    if (sync_clr) begin
      ptr_d   = 2'd0;
      burst_d = 4'd0;
    end
  end

  always_comb begin
    cap_data = data_0;
    unique case (inflight_src_q)
      2'd0: cap_data = data_0;
      2'd1: cap_data = data_1;
      2'd2: cap_data = data_2;
      2'd3: cap_data = data_3;
      default: cap_data = data_0;
    endcase
  end

  assign cap_word = {inflight_src_q, cap_data};

  always_comb begin
    inflight_d     = do_pop;
    inflight_src_d = do_pop ? chosen : inflight_src_q;
    head_d         = head_q;
    tail_d         = tail_q;
    occ_d          = occ_q;
    case ({accept, inflight_q})
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = cap_word;
        end else begin
          head_d = tail_q;
          tail_d = cap_word;
        end
      end
      2'b10: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) begin
          head_d = cap_word;
        end else begin
          tail_d = cap_word;
        end
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
    if (sync_clr) begin
      inflight_d     = 1'b0;
      inflight_src_d = 2'd0;
      head_d         = '0;
      tail_d         = '0;
      occ_d          = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q          <= 2'd0;
      burst_q        <= 4'd0;
      inflight_q     <= 1'b0;
      inflight_src_q <= 2'd0;
      head_q         <= '0;
      tail_q         <= '0;
      occ_q          <= 2'd0;
    end else begin
      ptr_q          <= ptr_d;
      burst_q        <= burst_d;
      inflight_q     <= inflight_d;
      inflight_src_q <= inflight_src_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      occ_q          <= occ_d;
    end
  end

  assign data_out = valid_out ? head_q[11:0] : 12'd0;
  assign src_out  = valid_out ? head_q[13:12] : 2'd0;
  assign idle     = ~reset_L | ((&empty_vec) & ~inflight_q & (occ_q == 2'd0));

endmodule
